// File: rtl/nios_system_myip_cpu_cpu_debug_host_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_myIP_cpu_debug_host_pkg
//  Description : Shared types and constants for the host-side virtual-JTAG
//                scan engine driving the Nios II debug slave.
//  Revision    : 1.0  initial release
// ============================================================================
package nios_system_myIP_cpu_debug_host_pkg;

  // Debug slave DR chain length and virtual IR width
  localparam int DBG_SR_WIDTH = 38;
  localparam int DBG_IR_WIDTH = 2;

  // Scan sequencer states; encodings are fixed so they can be reused as
  // plain logic constants by legacy-style state registers.
  typedef enum logic [2:0] {
    DBG_ST_IDLE = 3'd0,
    DBG_ST_UIR  = 3'd1,
    DBG_ST_CDR  = 3'd2,
    DBG_ST_SDR  = 3'd3,
    DBG_ST_UDR  = 3'd4,
    DBG_ST_RSP  = 3'd5
  } dbg_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit
  function automatic int dbg_cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nios_system_myip_cpu_cpu_debug_host_scan_tckgen.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_myIP_cpu_debug_host_tckgen
//  Description : Divided virtual TCK generator. TCK starts low for one half
//                period after enable, then toggles every TCK_DIV clocks.
//                tck_rise / tck_fall are one-clk pulses flagging the clock
//                edge on which tck changes.
//  Revision    : 1.0  initial release
// ============================================================================
module nios_system_myIP_cpu_debug_host_tckgen
  import nios_system_myIP_cpu_debug_host_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tck,
  output logic tck_rise,
  output logic tck_fall
);

  localparam int             CW   = dbg_cnt_width(TCK_DIV);
  localparam logic [CW-1:0]  LAST = CW'(TCK_DIV - 1);

  logic [CW-1:0] half_cnt;
  logic          half_done;

  // The edge that ends the current half period is the one that toggles tck
  assign half_done = en && (half_cnt == LAST);
  assign tck_rise  = half_done && !tck;
  assign tck_fall  = half_done && tck;

  // Half-period counter and TCK toggle; held cleared and low while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end else if (!en) begin
      half_cnt <= '0;
      tck      <= 1'b0;
    end else if (half_done) begin
      half_cnt <= '0;
      tck      <= ~tck;
    end else begin
      half_cnt <= half_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/nios_system_myip_cpu_cpu_debug_host_scan.sv
`default_nettype none
// ============================================================================
//  Module      : nios_system_myip_cpu_cpu_debug_host_scan
//  Description : Host-side scan engine for the Nios II debug slave virtual
//                JTAG port. Runs UIR / CDR / SDR / UDR with a divided TCK,
//                shifts the command DR word out on tdi, captures tdo and
//                returns the captured word through a valid/ready response.
//  Revision    : 1.0  initial release
// ============================================================================
module nios_system_myip_cpu_cpu_debug_host_scan
  import nios_system_myIP_cpu_debug_host_pkg::*;
#(
  parameter int TCK_DIV  = 2,
  parameter int SR_WIDTH = DBG_SR_WIDTH,
  parameter int IR_WIDTH = DBG_IR_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_ir_en,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [SR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [SR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr,
  output logic                jtag_state_rti
);

  localparam logic [2:0] S_IDLE = DBG_ST_IDLE;
  localparam logic [2:0] S_UIR  = DBG_ST_UIR;
  localparam logic [2:0] S_CDR  = DBG_ST_CDR;
  localparam logic [2:0] S_SDR  = DBG_ST_SDR;
  localparam logic [2:0] S_UDR  = DBG_ST_UDR;
  localparam logic [2:0] S_RSP  = DBG_ST_RSP;

  localparam int             BCW      = dbg_cnt_width(SR_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(SR_WIDTH - 1);

  logic [2:0]          state;
  logic                launch;      // first clk after accept: TCK not yet running
  logic [SR_WIDTH-1:0] sr;
  logic [SR_WIDTH-1:0] sr_shifted;
  logic [BCW-1:0]      bit_cnt;
  logic [IR_WIDTH-1:0] ir_cap;
  logic                accept;
  logic                active;
  logic                gen_en;
  logic                last_bit;
  logic                tck_rise;
  logic                tck_fall;

  assign cmd_ready      = (state == S_IDLE);
  assign accept         = cmd_valid && cmd_ready;
  assign rsp_valid      = (state == S_RSP);
  assign jtag_state_rti = (state == S_IDLE) || (state == S_RSP);
  assign active         = (state == S_UIR) || (state == S_CDR) ||
                          (state == S_SDR) || (state == S_UDR);
  assign gen_en         = active && !launch;
  assign last_bit       = (bit_cnt == LAST_BIT);

  // Strobes follow the phase but stay low during the launch clk so each
  // one spans exactly whole TCK periods.
  assign vs_uir = gen_en && (state == S_UIR);
  assign vs_cdr = gen_en && (state == S_CDR);
  assign vs_sdr = gen_en && (state == S_SDR);
  assign vs_udr = gen_en && (state == S_UDR);

  // Captured tdo enters at the MSB so the first captured bit ends at bit 0
  generate
    if (SR_WIDTH > 1) begin : g_shift_multi
      assign sr_shifted = {tdo, sr[SR_WIDTH-1:1]};
    end else begin : g_shift_single
      assign sr_shifted = tdo;
    end
  endgenerate

  nios_system_myIP_cpu_debug_host_tckgen #(
    .TCK_DIV (TCK_DIV)
  ) u_tckgen (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (gen_en),
    .tck      (tck),
    .tck_rise (tck_rise),
    .tck_fall (tck_fall)
  );

  // Phase sequencer; every phase boundary sits on a TCK falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      launch <= 1'b0;
    end else begin
      launch <= accept;
      case (state)
        S_IDLE: if (cmd_valid) state <= cmd_ir_en ? S_UIR : S_CDR;
        S_UIR:  if (tck_fall) state <= S_CDR;
        S_CDR:  if (tck_fall) state <= S_SDR;
        S_SDR:  if (tck_fall && last_bit) state <= S_UDR;
        S_UDR:  if (tck_fall) state <= S_RSP;
        S_RSP:  if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Shift register and bit counter: load on accept, shift on SDR rising edges
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      sr      <= cmd_dr;
      bit_cnt <= '0;
    end else if (state == S_SDR) begin
      if (tck_rise) begin
        sr <= sr_shifted;
      end
      if (tck_fall && !last_bit) begin
        bit_cnt <= bit_cnt + BCW'(1);
      end
    end
  end

  // tdi changes only at period starts; zero outside the SDR shift window
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tdi <= 1'b0;
    end else if (tck_fall) begin
      if (state == S_CDR) begin
        tdi <= sr[0];
      end else if (state == S_SDR) begin
        tdi <= last_bit ? 1'b0 : sr[0];
      end else begin
        tdi <= 1'b0;
      end
    end
  end

  // Virtual IR: loaded on an IR-carrying accept, readback sampled in UIR
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_in  <= '0;
      ir_cap <= '0;
    end else begin
      if (accept && cmd_ir_en) begin
        ir_in <= cmd_ir;
      end
      if ((state == S_UIR) && tck_rise) begin
        ir_cap <= ir_out;
      end
    end
  end

  // Response registers update once, at the UDR to RSP boundary
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_dr     <= '0;
      rsp_ir_out <= '0;
    end else if ((state == S_UDR) && tck_fall) begin
      rsp_dr     <= sr;
      rsp_ir_out <= ir_cap;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_system_myip_cpu_cpu_debug_host_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nios_system_myip_cpu_cpu_debug_host_scan
//  Description : Self-checking bench for the debug host scan engine. One
//                instance at TCK_DIV=2, a second at TCK_DIV=1.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_nios_system_myip_cpu_cpu_debug_host_scan;

  localparam int TD  = 2;
  localparam int W   = 38;
  localparam int IRW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (TCK_DIV = 2) ----------------
  logic           reset_n;
  logic           cmd_valid, cmd_ready, cmd_ir_en;
  logic [IRW-1:0] cmd_ir;
  logic [W-1:0]   cmd_dr;
  logic           rsp_valid, rsp_ready;
  logic [W-1:0]   rsp_dr;
  logic [IRW-1:0] rsp_ir_out;
  logic           tck, tdi, tdo;
  logic [IRW-1:0] ir_in, ir_out;
  logic           vs_uir, vs_cdr, vs_sdr, vs_udr, jtag_state_rti;

  logic           loop_mode;
  logic [W-1:0]   tdo_word;
  logic           tdo_pat;
  assign tdo = loop_mode ? tdi : tdo_pat;

  nios_system_myip_cpu_cpu_debug_host_scan #(.TCK_DIV(TD), .SR_WIDTH(W), .IR_WIDTH(IRW)) u_dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ir_en(cmd_ir_en), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out), .tck(tck),
    .tdi(tdi), .tdo(tdo), .ir_in(ir_in), .ir_out(ir_out), .vs_uir(vs_uir),
    .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .jtag_state_rti(jtag_state_rti)
  );

  // ---------------- DUT B (TCK_DIV = 1, loopback) ----------------
  logic           b_cmd_valid, b_cmd_ready;
  logic [W-1:0]   b_cmd_dr;
  logic           b_rsp_valid, b_rsp_ready;
  logic [W-1:0]   b_rsp_dr;
  logic [IRW-1:0] b_rsp_ir_out, b_ir_in;
  logic           b_tck, b_tdi;
  logic           b_vs_uir, b_vs_cdr, b_vs_sdr, b_vs_udr, b_rti;
  logic [IRW-1:0] b_ir_out = 2'b01;

  nios_system_myip_cpu_cpu_debug_host_scan #(.TCK_DIV(1), .SR_WIDTH(W), .IR_WIDTH(IRW)) u_dut_div1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
    .cmd_ir_en(1'b1), .cmd_ir(2'b11), .cmd_dr(b_cmd_dr), .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready), .rsp_dr(b_rsp_dr), .rsp_ir_out(b_rsp_ir_out), .tck(b_tck),
    .tdi(b_tdi), .tdo(b_tdi), .ir_in(b_ir_in), .ir_out(b_ir_out), .vs_uir(b_vs_uir),
    .vs_cdr(b_vs_cdr), .vs_sdr(b_vs_sdr), .vs_udr(b_vs_udr), .jtag_state_rti(b_rti)
  );

  // ---------------- observation (sampled on falling clk edges) ----------------
  int n_acc = 0, n_rsp = 0, acc_edge = 0, rise_edge = 0, hs_edge = 0;
  int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0, n_ovl = 0, n_sdr_rise = 0;
  logic prev_tck = 1'b0, prev_rv = 1'b0;

  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      n_acc      <= n_acc + 1;
      acc_edge   <= cyc + 1;
      n_uir      <= 0; n_cdr <= 0; n_sdr <= 0; n_udr <= 0; n_ovl <= 0;
      n_sdr_rise <= 0;
      tdo_pat    <= tdo_word[0];
    end else begin
      if (vs_uir) n_uir <= n_uir + 1;
      if (vs_cdr) n_cdr <= n_cdr + 1;
      if (vs_sdr) n_sdr <= n_sdr + 1;
      if (vs_udr) n_udr <= n_udr + 1;
      if ((int'(vs_uir) + int'(vs_cdr) + int'(vs_sdr) + int'(vs_udr)) > 1) n_ovl <= n_ovl + 1;
      if (tck && !prev_tck && vs_sdr) begin
        n_sdr_rise <= n_sdr_rise + 1;
        if (n_sdr_rise + 1 < W) tdo_pat <= tdo_word[n_sdr_rise + 1];
      end
    end
    if (rsp_valid && !prev_rv) begin
      n_rsp     <= n_rsp + 1;
      rise_edge <= cyc;
    end
    if (rsp_valid && rsp_ready) hs_edge <= cyc + 1;
    prev_tck <= tck;
    prev_rv  <= rsp_valid;
  end

  int   b_acc_edge = 0, b_rise_edge = 0, b_rises = 0, b_bad = 0;
  logic b_prev_tck = 1'b0, b_prev_vs = 1'b0, b_prev_rv = 1'b0;
  logic b_vs_any;
  assign b_vs_any = b_vs_uir | b_vs_cdr | b_vs_sdr | b_vs_udr;

  always @(negedge clk) begin
    if (b_cmd_valid && b_cmd_ready) begin
      b_acc_edge <= cyc + 1;
      b_rises    <= 0;
      b_bad      <= 0;
    end else begin
      if (b_tck && !b_prev_tck) b_rises <= b_rises + 1;
      if (b_vs_any && b_prev_vs && (b_tck == b_prev_tck)) b_bad <= b_bad + 1;
    end
    if (b_rsp_valid && !b_prev_rv) b_rise_edge <= cyc;
    b_prev_tck <= b_tck;
    b_prev_vs  <= b_vs_any;
    b_prev_rv  <= b_rsp_valid;
  end

  // ---------------- reference model state ----------------
  int             checks = 0;
  int             errors = 0;
  logic [W-1:0]   exp_dr;
  logic [IRW-1:0] exp_iri, exp_iro;
  int             exp_lat, exp_uir;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a command and derive every expected result from the scan rules
  task automatic issue_a(input logic ir_en, input logic [IRW-1:0] ir, input logic [W-1:0] dr,
                         input logic loop, input logic [W-1:0] pat, input logic [IRW-1:0] iro);
    int periods;
    cmd_ir_en = ir_en; cmd_ir = ir; cmd_dr = dr;
    loop_mode = loop;  tdo_word = pat; ir_out = iro;
    cmd_valid = 1'b1;
    exp_dr  = loop ? dr : pat;
    if (ir_en) begin
      exp_iri = ir;
      exp_iro = iro;
    end
    periods = (ir_en ? 1 : 0) + 1 + W + 1;
    exp_lat = 2 * TD * periods + 1;
    exp_uir = ir_en ? 2 * TD : 0;
  endtask

  task automatic accept_a(input string tag);
    int start = n_acc;
    int k = 0;
    do begin
      tick();
      k++;
    end while (n_acc == start && k < 1000);
    cmd_valid = 1'b0;
    check({tag, "_accepted"}, 64'(n_acc - start), 64'd1);
  endtask

  task automatic check_a(input string tag);
    int k = 0;
    while (!rsp_valid && k < 2000) begin
      tick();
      k++;
    end
    @(negedge clk);
    #1;
    check({tag, "_rsp_valid"},  64'(rsp_valid), 64'd1);
    check({tag, "_rsp_dr"},     64'(rsp_dr), 64'(exp_dr));
    check({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'(exp_iro));
    check({tag, "_ir_in"},      64'(ir_in), 64'(exp_iri));
    check({tag, "_latency"},    64'(rise_edge - acc_edge), 64'(exp_lat));
    check({tag, "_uir_clks"},   64'(n_uir), 64'(exp_uir));
    check({tag, "_cdr_clks"},   64'(n_cdr), 64'(2 * TD));
    check({tag, "_sdr_clks"},   64'(n_sdr), 64'(2 * TD * W));
    check({tag, "_udr_clks"},   64'(n_udr), 64'(2 * TD));
    check({tag, "_overlap"},    64'(n_ovl), 64'd0);
    check({tag, "_sdr_rises"},  64'(n_sdr_rise), 64'(W));
  endtask

  task automatic release_a(input string tag);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_ready_after_hs"}, 64'(cmd_ready), 64'd1);
    check({tag, "_valid_after_hs"}, 64'(rsp_valid), 64'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tck"},        64'(tck), 64'd0);
    check({tag, "_tdi"},        64'(tdi), 64'd0);
    check({tag, "_ir_in"},      64'(ir_in), 64'd0);
    check({tag, "_vs"},         64'({vs_uir, vs_cdr, vs_sdr, vs_udr}), 64'd0);
    check({tag, "_rti"},        64'(jtag_state_rti), 64'd1);
    check({tag, "_cmd_ready"},  64'(cmd_ready), 64'd1);
    check({tag, "_rsp_valid"},  64'(rsp_valid), 64'd0);
    check({tag, "_rsp_dr"},     64'(rsp_dr), 64'd0);
    check({tag, "_rsp_ir_out"}, 64'(rsp_ir_out), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [63:0]    rnd;
    logic [W-1:0]   held;
    logic [W-1:0]   pat;
    logic [IRW-1:0] iro;
    int             start;
    int             k;

    reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_ir_en = 1'b0; cmd_ir = '0; cmd_dr = '0;
    rsp_ready = 1'b0; ir_out = '0; loop_mode = 1'b0; tdo_word = '0;
    b_cmd_valid = 1'b0; b_cmd_dr = '0; b_rsp_ready = 1'b0;
    exp_iri = '0; exp_iro = '0; exp_dr = '0; exp_lat = 0; exp_uir = 0;
    repeat (3) tick();
    check_reset_vals("reset");
    reset_n = 1'b1;
    tick();

    // Loopback with an IR phase
    issue_a(1'b1, 2'b01, 38'h2A_5555_AAAA, 1'b1, '0, 2'b10);
    accept_a("loop");
    check_a("loop");
    release_a("loop");

    // Constant-one tdo, IR skipped: ir_in and rsp_ir_out keep old values
    issue_a(1'b0, 2'b11, '0, 1'b0, '1, 2'b01);
    accept_a("ones");
    check_a("ones");
    release_a("ones");

    // Random commands against the model
    for (int i = 0; i < 4; i++) begin
      rnd = {$urandom(), $urandom()};
      pat = rnd[W-1:0];
      rnd = {$urandom(), $urandom()};
      iro = IRW'($urandom_range(0, 3));
      issue_a(1'($urandom_range(0, 1)), IRW'($urandom_range(0, 3)), rnd[W-1:0], 1'b0, pat, iro);
      accept_a("rand");
      check_a("rand");
      release_a("rand");
    end

    // Response backpressure with a pending command
    rnd = {$urandom(), $urandom()};
    issue_a(1'b1, 2'b10, rnd[W-1:0], 1'b1, '0, 2'b11);
    accept_a("bp_first");
    check_a("bp_first");
    held  = rsp_dr;
    start = n_acc;
    rnd = {$urandom(), $urandom()};
    issue_a(1'b0, 2'b00, rnd[W-1:0], 1'b1, '0, 2'b00);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_rsp_valid_held", 64'(rsp_valid), 64'd1);
      check("bp_rsp_dr_stable",  64'(rsp_dr), 64'(held));
    end
    check("bp_no_accept", 64'(n_acc - start), 64'd0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_ready_same_cycle", 64'(cmd_ready), 64'd1);
    accept_a("bp_second");
    check("bp_accept_after_hs", 64'(acc_edge), 64'(hs_edge + 1));
    check_a("bp_second");
    release_a("bp_second");

    // Reset pulsed in the middle of SDR
    rnd = {$urandom(), $urandom()};
    issue_a(1'b1, 2'b11, rnd[W-1:0], 1'b1, '0, 2'b01);
    accept_a("mid_reset");
    k = 0;
    while (n_sdr_rise < 11 && k < 1000) begin
      tick();
      k++;
    end
    check("mid_reset_reached_sdr", 64'(n_sdr_rise >= 11), 64'd1);
    start = n_rsp;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    exp_iri = '0;
    exp_iro = '0;
    tick();
    reset_n = 1'b1;
    repeat (200) tick();
    check("no_rsp_after_reset", 64'(n_rsp - start), 64'd0);
    rnd = {$urandom(), $urandom()};
    pat = rnd[W-1:0];
    rnd = {$urandom(), $urandom()};
    issue_a(1'b0, 2'b00, rnd[W-1:0], 1'b0, pat, 2'b10);
    accept_a("post_reset");
    check_a("post_reset");
    release_a("post_reset");

    // TCK_DIV = 1 loopback on the second instance
    rnd = {$urandom(), $urandom()};
    b_cmd_dr    = rnd[W-1:0];
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    k = 0;
    while (!b_rsp_valid && k < 1000) begin
      tick();
      k++;
    end
    @(negedge clk);
    #1;
    check("div1_rsp_valid",   64'(b_rsp_valid), 64'd1);
    check("div1_rsp_dr",      64'(b_rsp_dr), 64'(rnd[W-1:0]));
    check("div1_rsp_ir_out",  64'(b_rsp_ir_out), 64'(2'b01));
    check("div1_ir_in",       64'(b_ir_in), 64'(2'b11));
    check("div1_latency",     64'(b_rise_edge - b_acc_edge), 64'(2 * 1 * (W + 3) + 1));
    check("div1_tck_rises",   64'(b_rises), 64'(W + 3));
    check("div1_toggle_miss", 64'(b_bad), 64'd0);
    b_rsp_ready = 1'b1;
    tick();
    b_rsp_ready = 1'b0;
    check("div1_ready_after_hs", 64'(b_cmd_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
